mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single line-wide main-memory port between I-cache line fills and D-cache line fills/write-backs.
- Sits between both caches and the memory model, below the pipeline hazard controller. That controller's ACCESS_I/ACCESS_D/BOTH_I_D stalls end on this block's i_ready/d_ready pulses.
- One memory transaction runs at a time, with a fixed memory latency.
- Arbitration is D-priority with an I starvation guard.

Parameters:
- WORD_SIZE, 16, bits per word.
- LINE_WORDS, 4, words per cache line (power of two, >=2).
- LATENCY, 4, memory cycles per transaction (>=1).
- STARVE_LIMIT, 2, maximum consecutive D grants while I waits (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_req  in  1  I-cache line-read request, level; held until i_ready.
- i_addr  in  WORD_SIZE  I-cache miss address.
- i_ready  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  LINE_WORDS*WORD_SIZE  I line data.
- d_req  in  1  D-cache request, level; held until d_ready.
- d_write  in  1  1 = line write-back, 0 = line read.
- d_addr  in  WORD_SIZE  D address.
- d_wdata  in  LINE_WORDS*WORD_SIZE  write-back line.
- d_ready  out  1  one-cycle pulse; transaction done (d_rdata valid on reads).
- d_rdata  out  LINE_WORDS*WORD_SIZE  D line data.
- mem_read  out  1  memory read strobe, held for the whole transaction.
- mem_write  out  1  memory write strobe, held for the whole transaction.
- mem_addr  out  WORD_SIZE  line-aligned address.
- mem_wdata  out  LINE_WORDS*WORD_SIZE  write line.
- mem_rdata  in  LINE_WORDS*WORD_SIZE  read line from memory, valid in the last BUSY cycle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n low at a rising clk edge):
  - state goes to IDLE; latency counter, streak counter and all captured registers are cleared.
  - All outputs are 0, including both rdata buses.
  - A transaction in flight is aborted with no ready pulse; strobes drop after that edge.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Output decode (from state and registers only; no combinational path from req to any output):
  - mem_read = BUSY_I, or BUSY_D with the latched write flag 0.
  - mem_write = BUSY_D with the latched write flag 1.
  - i_ready = DONE_I; d_ready = DONE_D.
- IDLE grant rule, evaluated every cycle:
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both pending: BUSY_I if streak == STARVE_LIMIT, otherwise BUSY_D.
  - Neither: stay in IDLE.
- Streak counter:
  - D grant with i_req high: increment, saturating at STARVE_LIMIT.
  - D grant with i_req low: clear.
  - I grant: clear.
- Grant edge latches addr (low log2(LINE_WORDS) bits forced to 0), d_write and d_wdata; latency counter is set to 0.
- BUSY_x: counter increments each cycle.
  - At counter == LATENCY-1, capture mem_rdata into the granted requester's rdata register (reads only), then go to DONE_x.
  - mem_addr and mem_wdata stay stable for the whole BUSY period.
- DONE_x: ready is high for exactly one cycle, then IDLE. No grant is made in DONE.
- Requester drops req on the edge ending its ready cycle. An IDLE-cycle req is therefore always a new request.
- Latency: req first sampled in IDLE at cycle t gives BUSY at t+1..t+LATENCY and ready at t+LATENCY+1. Minimum spacing of back-to-back transactions is LATENCY+2 cycles.
- Data hold: i_rdata/d_rdata keep their value until the next capture for that requester; a write-back does not change d_rdata.
- Requests arriving during BUSY/DONE wait, with no loss, and are arbitrated in the next IDLE cycle.
- Counter width is clog2(LATENCY)+1; it never wraps within a transaction.

Decomposition:
- Shared header (alongside the opcode/WORD_SIZE defines) holds:
  - WORD_SIZE and LINE_WORDS defines.
  - Arbiter state encodings (3-bit).
- One optional sub-module, mem_latency_timer: loadable counter with a done flag at LATENCY-1, reusable by the cache FSMs.
- Everything else stays in the top-level module.

Test Plan:
- Reset mid-BUSY_D (LATENCY=4, reset_n low in busy cycle 2) -> next cycle: all outputs 0, no d_ready, state IDLE; a fresh i_req then gives i_ready 5 cycles after first sample.
- Lone I read, i_addr=0x0013, mem_rdata=0x1111_2222_3333_4444 -> mem_addr=0x0010 and mem_read high for 4 cycles, i_ready one pulse at t+5, i_rdata equals the line.
- D write-back, d_addr=0x0042, d_wdata=0xAAAA_BBBB_CCCC_DDDD -> mem_write for 4 cycles with mem_addr=0x0040 and stable wdata; d_ready at t+5; mem_read stays 0; d_rdata unchanged.
- i_req and d_req asserted together at t -> D served first (d_ready t+5); I granted at t+6, i_ready t+11.
- i_req held while d_req is re-asserted after every d_ready (STARVE_LIMIT=2) -> grant order D, D, I, D; streak returns to 0 after the I grant.
- d_req raised during BUSY_I -> no change to mem strobes until DONE_I; D granted the first IDLE cycle after i_ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizes for the main-memory port arbiter: line geometry,
// arbiter state encodings and the line-alignment helper.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_SIZE * LINE_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } arb_state_e;

  // Clears the word-offset bits so memory always sees a line address.
  function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] a);
    return a & ~WORD_SIZE'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the cache-side request buses and the memory-side port.
// master = caches plus memory model, slave = the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // req is a level held until the matching one-cycle ready pulse; the
  // requester drops req on the edge that ends its ready cycle.
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_ready;
  logic [LINE_W-1:0]    i_rdata;
  logic                 d_req;
  logic                 d_write;
  logic [WORD_SIZE-1:0] d_addr;
  logic [LINE_W-1:0]    d_wdata;
  logic                 d_ready;
  logic [LINE_W-1:0]    d_rdata;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [LINE_W-1:0]    mem_wdata;
  logic [LINE_W-1:0]    mem_rdata;
  logic                 busy;

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write,
           mem_addr, mem_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write,
           mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Loadable up-counter flagging the last cycle of a fixed-latency access.
// Counter is one bit wider than needed so it cannot wrap inside a transaction.
module mem_latency_timer #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(LATENCY) + 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)    cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign done_o = (cnt_q == CW'(LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I-cache fills and D-cache
// fills/write-backs; D has priority, I is forced in after a D streak.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY      = 4,
  parameter int STARVE_LIMIT = 2,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_port_arbiter_if.slave bus,
  output arb_state_e      state_o,
  output logic [SW-1:0]   streak_o
);

  arb_state_e           state_q;
  logic [SW-1:0]        streak_q, streak_d;
  logic [WORD_SIZE-1:0] addr_q;
  logic                 wr_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [LINE_W-1:0]    i_rdata_q;
  logic [LINE_W-1:0]    d_rdata_q;
  logic                 grant_i, grant_d;
  logic                 tmr_en, tmr_done;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      grant_d = bus.d_req && !(bus.i_req && streak_q == SW'(STARVE_LIMIT));
      grant_i = bus.i_req && !grant_d;
    end
    // Streak counts D wins taken while I was waiting; any other grant resets it.
    if (grant_d) begin
      if (!bus.i_req)                          streak_d = '0;
      else if (streak_q != SW'(STARVE_LIMIT))  streak_d = streak_q + 1'b1;
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  assign tmr_en = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  mem_latency_timer #(.LATENCY(LATENCY)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (grant_i || grant_d),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      streak_q <= streak_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            state_q <= ST_BUSY_D;
            addr_q  <= line_align(bus.d_addr);
            wr_q    <= bus.d_write;
            wdata_q <= bus.d_wdata;
          end else if (grant_i) begin
            state_q <= ST_BUSY_I;
            addr_q  <= line_align(bus.i_addr);
            wr_q    <= 1'b0;
          end
        end
        ST_BUSY_I: begin
          if (tmr_done) begin
            i_rdata_q <= bus.mem_rdata;
            state_q   <= ST_DONE_I;
          end
        end
        ST_BUSY_D: begin
          if (tmr_done) begin
            if (!wr_q) d_rdata_q <= bus.mem_rdata;
            state_q <= ST_DONE_D;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_read  = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D && !wr_q);
  assign bus.mem_write = (state_q == ST_BUSY_D) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ready   = (state_q == ST_DONE_I);
  assign bus.d_ready   = (state_q == ST_DONE_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign state_o       = state_q;
  assign streak_o      = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, lone I/D transactions,
// simultaneous requests, starvation guard, late request and mid-busy reset.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic       clk;
  logic       reset_n;
  arb_state_e state_o;
  logic [1:0] streak_o;
  int         pass_cnt;
  int         total_cnt;
  int         who;
  int         exp_order [4];
  int         exp_streak[4];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.LATENCY(4), .STARVE_LIMIT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .state_o (state_o),
    .streak_o(streak_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Returns 1 for i_ready, 2 for d_ready, 0 if neither shows within the budget.
  task automatic wait_ready(output int w);
    w = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.i_ready) begin w = 1; break; end
      if (bus.d_ready) begin w = 2; break; end
    end
    if (w == 0) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(bus.busy),      64'd0);
    chk({tag, "_rd"},    64'(bus.mem_read),  64'd0);
    chk({tag, "_wr"},    64'(bus.mem_write), 64'd0);
    chk({tag, "_irdy"},  64'(bus.i_ready),   64'd0);
    chk({tag, "_drdy"},  64'(bus.d_ready),   64'd0);
    chk({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
    chk({tag, "_wdata"}, bus.mem_wdata,      64'd0);
    chk({tag, "_irdata"}, bus.i_rdata,       64'd0);
    chk({tag, "_drdata"}, bus.d_rdata,       64'd0);
    chk({tag, "_state"}, 64'(state_o),       64'(ST_IDLE));
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    exp_order  = '{2, 2, 1, 2};
    exp_streak = '{1, 2, 0, 0};
    reset_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;

    tick(); tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Lone I read
    bus.i_addr = 16'h0013; bus.mem_rdata = 64'h1111_2222_3333_4444; bus.i_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("iread_rd",   64'(bus.mem_read),  64'd1);
      chk("iread_wr",   64'(bus.mem_write), 64'd0);
      chk("iread_addr", 64'(bus.mem_addr),  64'h0010);
      chk("iread_rdy",  64'(bus.i_ready),   64'd0);
    end
    tick();
    chk("iread_rdy5", 64'(bus.i_ready), 64'd1);
    chk("iread_data", bus.i_rdata, 64'h1111_2222_3333_4444);
    chk("iread_rd_off", 64'(bus.mem_read), 64'd0);
    bus.i_req = 1'b0;
    tick();
    chk("iread_pulse", 64'(bus.i_ready), 64'd0);
    chk("iread_idle", 64'(state_o), 64'(ST_IDLE));

    // D read, gives d_rdata a known value for the write-back check
    bus.d_addr = 16'h0025; bus.d_write = 1'b0; bus.mem_rdata = 64'h5555_6666_7777_8888;
    bus.d_req = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    chk("dread_addr", 64'(bus.mem_addr), 64'h0024);
    tick();
    chk("dread_rdy",  64'(bus.d_ready), 64'd1);
    chk("dread_data", bus.d_rdata, 64'h5555_6666_7777_8888);
    bus.d_req = 1'b0;
    tick();

    // D write-back
    bus.d_addr = 16'h0042; bus.d_wdata = 64'hAAAA_BBBB_CCCC_DDDD; bus.d_write = 1'b1;
    bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; bus.d_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("dwr_wr",    64'(bus.mem_write), 64'd1);
      chk("dwr_rd",    64'(bus.mem_read),  64'd0);
      chk("dwr_addr",  64'(bus.mem_addr),  64'h0040);
      chk("dwr_wdata", bus.mem_wdata,      64'hAAAA_BBBB_CCCC_DDDD);
    end
    tick();
    chk("dwr_rdy",   64'(bus.d_ready), 64'd1);
    chk("dwr_rdata", bus.d_rdata, 64'h5555_6666_7777_8888);
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    tick();

    // Simultaneous I and D: D first, I granted the IDLE cycle after d_ready
    bus.i_addr = 16'h0100; bus.d_addr = 16'h0200; bus.mem_rdata = 64'h0D0D_0D0D_0D0D_0D0D;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick();
    chk("both_first", 64'(state_o), 64'(ST_BUSY_D));
    chk("both_streak1", 64'(streak_o), 64'd1);
    tick(); tick(); tick();
    chk("both_daddr", 64'(bus.mem_addr), 64'h0200);
    tick();
    chk("both_drdy", 64'(bus.d_ready), 64'd1);
    chk("both_irdy_lo", 64'(bus.i_ready), 64'd0);
    chk("both_ddata", bus.d_rdata, 64'h0D0D_0D0D_0D0D_0D0D);
    bus.d_req = 1'b0;
    tick();
    chk("both_idle6", 64'(state_o), 64'(ST_IDLE));
    bus.mem_rdata = 64'h0101_0202_0303_0404;
    tick();
    chk("both_ibusy", 64'(state_o), 64'(ST_BUSY_I));
    chk("both_streak0", 64'(streak_o), 64'd0);
    chk("both_iaddr", 64'(bus.mem_addr), 64'h0100);
    tick(); tick(); tick();
    chk("both_irdy_early", 64'(bus.i_ready), 64'd0);
    tick();
    chk("both_irdy11", 64'(bus.i_ready), 64'd1);
    chk("both_idata", bus.i_rdata, 64'h0101_0202_0303_0404);
    bus.i_req = 1'b0;
    tick();

    // Starvation guard: I held, D re-requesting after every d_ready
    bus.i_addr = 16'h0600; bus.d_addr = 16'h0700; bus.d_write = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ready(who);
      chk($sformatf("starve_order%0d", g), 64'(who), 64'(exp_order[g]));
      chk($sformatf("starve_streak%0d", g), 64'(streak_o), 64'(exp_streak[g]));
      if (who == 1) bus.i_req = 1'b0;
    end
    bus.d_req = 1'b0;
    tick();

    // D request arriving mid BUSY_I waits until the next IDLE cycle
    bus.i_addr = 16'h0300; bus.i_req = 1'b1;
    tick();
    bus.d_addr = 16'h0400; bus.d_write = 1'b0; bus.d_req = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("late_state", 64'(state_o), 64'(ST_BUSY_I));
      chk("late_addr",  64'(bus.mem_addr), 64'h0300);
    end
    tick();
    chk("late_irdy", 64'(bus.i_ready), 64'd1);
    bus.i_req = 1'b0;
    tick();
    chk("late_idle", 64'(state_o), 64'(ST_IDLE));
    tick();
    chk("late_dgrant", 64'(state_o), 64'(ST_BUSY_D));
    chk("late_daddr", 64'(bus.mem_addr), 64'h0400);
    wait_ready(who);
    chk("late_dready", 64'(who), 64'd2);
    bus.d_req = 1'b0;
    tick();

    // Reset in the second BUSY_D cycle aborts without d_ready
    bus.d_addr = 16'h0500; bus.d_write = 1'b1; bus.d_req = 1'b1;
    tick(); tick();
    reset_n = 1'b0; bus.d_req = 1'b0;
    tick();
    chk_all_zero("midrst");
    reset_n = 1'b1;
    bus.i_addr = 16'h0013; bus.mem_rdata = 64'h9999_8888_7777_6666; bus.i_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("postrst_drdy", 64'(bus.d_ready), 64'd0);
    end
    tick();
    chk("postrst_irdy", 64'(bus.i_ready), 64'd1);
    chk("postrst_idata", bus.i_rdata, 64'h9999_8888_7777_6666);
    bus.i_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
